mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle sequencing controller for the MIPS core. It replaces single-cycle decode with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared instruction/data memory port with a request/ready handshake, and drives the register file, ALU, sign-extender, PC and IR enables. It sits between the IR fields (`OPCODE`/`FUNCT`), the ALU `ZERO` flag, and the datapath muxes.

## Interface
- `WAIT_MAX`, default 15: maximum memory wait cycles before `MEM_TIMEOUT`. Counter width is `$clog2(WAIT_MAX+1)`.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `OPCODE`  in  6  IR[31:26]
- `FUNCT`  in  6  IR[5:0]
- `ZERO`  in  1  ALU zero flag
- `MEM_READY`  in  1  memory completes the current access this cycle
- `MEM_REQ`  out  1  memory access request
- `ADDR_SRC`  out  1  memory address select: 0 = PC, 1 = ALU result register
- `MEM_WRITE`  out  1  store strobe, valid with `MEM_REQ`
- `IR_WRITE`  out  1  load IR from memory read data
- `PC_WRITE`  out  1  PC update enable
- `PC_SRC`  out  1  PC source: 0 = PC+4, 1 = branch target
- `REG_DST`  out  1  destination register: 1 = rd, 0 = rt
- `REG_WRITE`  out  1  register file write enable
- `EX_TOP`  out  1  extension mode: 1 = sign-extend, 0 = zero-extend
- `ALU_SRC`  out  1  ALU B operand: 1 = immediate, 0 = rt
- `ALU_OP`  out  4  ALU op: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, LHI 1000, LLO 1001
- `MEM2REG`  out  1  writeback source: 1 = ALU, 0 = memory data
- `INSTR_DONE`  out  1  one-cycle pulse on retire
- `ILLEGAL`  out  1  illegal-instruction flag
- `MEM_TIMEOUT`  out  1  sticky flag: wait limit exceeded

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP.
- **FETCH**
  - `MEM_REQ`=1, `ADDR_SRC`=0.
  - On `MEM_READY`: `IR_WRITE`=1, `PC_WRITE`=1, `PC_SRC`=0, then go to DECODE.
- **DECODE**, by `OPCODE`:
  - 000000 → EXEC_R if `FUNCT` ∈ {100000, 100010, 100100, 100101, 101010}; otherwise illegal.
  - 001000 / 011001 / 011000 → EXEC_I.
  - 100011 / 101011 → MEM_ADDR.
  - 000100 → BRANCH.
  - Any other opcode → illegal.
- **EXEC_R**: `ALU_SRC`=0, `ALU_OP` from `FUNCT`, then WB_ALU.
- **EXEC_I**: `ALU_SRC`=1, then WB_ALU.
  - ADDI: `EX_TOP`=1, ADD.
  - LHI: `EX_TOP`=0, op 1000.
  - LLO: `EX_TOP`=0, op 1001.
- **MEM_ADDR**: `ALU_SRC`=1, `EX_TOP`=1, ADD. Then MEM_RD for LW, MEM_WR for SW.
- **MEM_RD**: `MEM_REQ`=1, `ADDR_SRC`=1. On `MEM_READY` → WB_MEM.
- **MEM_WR**: `MEM_REQ`=1, `ADDR_SRC`=1, `MEM_WRITE`=1. On `MEM_READY` → FETCH with `INSTR_DONE`.
- **WB_ALU**: `REG_WRITE`=1, `MEM2REG`=1. `REG_DST`=1 for R-type, 0 for I-type. → FETCH with `INSTR_DONE`.
- **WB_MEM**: `REG_WRITE`=1, `MEM2REG`=0, `REG_DST`=0. → FETCH with `INSTR_DONE`.
- **BRANCH**: `ALU_SRC`=0, SUB. `PC_WRITE`=`ZERO`, `PC_SRC`=1. → FETCH with `INSTR_DONE`.
- Output rules:
  - Outputs are combinational from the current state and latched decode class.
  - `PC_WRITE`/`IR_WRITE` in FETCH and `PC_WRITE` in BRANCH are also qualified by their inputs.
  - Any output not listed for a state is 0.
- **Handshake**
  - `MEM_REQ`, `ADDR_SRC` and `MEM_WRITE` hold stable until the cycle in which `MEM_READY`=1.
  - `MEM_READY` is ignored while `MEM_REQ`=0.
- **Wait counter**
  - Counts cycles with `MEM_REQ`=1 and `MEM_READY`=0; clears on handshake.
  - Reaching `WAIT_MAX` sets `MEM_TIMEOUT` (sticky until reset). The state machine keeps waiting.

## Timing
- Reset: on a clock edge with `rst_n`=0, the state becomes FETCH and `ILLEGAL`, `MEM_TIMEOUT` and the wait counter clear.
- While `rst_n`=0, every output is forced to 0.
- First cycle after reset release: `MEM_REQ`=1, `ADDR_SRC`=0.
- Latency with zero memory wait, in cycles:
  - R-type: 4
  - ADDI/LHI/LLO: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - Each memory wait cycle adds 1.
- `INSTR_DONE` is asserted in the last cycle of each instruction.
- Reset asserted mid-instruction or mid-access aborts it on that edge. No write strobe is issued in the reset cycle.

## Configuration
- `MIPS_CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal instruction in DECODE → TRAP and sets `ILLEGAL`.
  - TRAP holds all outputs at 0 until reset.
- Undefined:
  - An illegal instruction is a NOP: DECODE → FETCH with `INSTR_DONE`=1.
  - `ILLEGAL` pulses for that one cycle; no state or register is modified.

## Test plan
- ADD (op 000000, funct 100000), `MEM_READY` tied 1 → FETCH/DECODE/EXEC_R/WB_ALU. `ALU_OP`=0010, `REG_DST`=1, `REG_WRITE`=1 in cycle 4, `INSTR_DONE` in cycle 4.
- LW (100011), `MEM_READY` low for 3 cycles in MEM_RD → `MEM_REQ`/`ADDR_SRC`=1 stable for 4 cycles. Then WB_MEM with `MEM2REG`=0, `REG_DST`=0; total 8 cycles.
- BEQ with `ZERO`=1 then `ZERO`=0 → `PC_WRITE`=1, `PC_SRC`=1, `ALU_OP`=0110 in cycle 3 of the first; `PC_WRITE`=0 in cycle 3 of the second.
- SW (101011) → `MEM_WRITE`=1 only in MEM_WR, `REG_WRITE` never asserted. `MEM_READY` held 0 for `WAIT_MAX`=15 cycles → `MEM_TIMEOUT`=1 and remains 1 after completion.
- Opcode 111111, run with macro on and off → on: TRAP with `ILLEGAL`=1 held, no `MEM_REQ`. Off: `ILLEGAL` and `INSTR_DONE` pulse in cycle 2, next FETCH in cycle 3.
- `rst_n`=0 during MEM_WR wait → all outputs 0 that cycle. After release, FETCH with `MEM_REQ`=1 and flags cleared.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencing controller: fetch/decode/execute/memory/writeback FSM
// with memory handshake and wait watchdog. Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap on illegal instructions.
`timescale 1ns/1ps

module mips_multicycle_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       ZERO,
    input  logic       MEM_READY,
    output logic       MEM_REQ,
    output logic       ADDR_SRC,
    output logic       MEM_WRITE,
    output logic       IR_WRITE,
    output logic       PC_WRITE,
    output logic       PC_SRC,
    output logic       REG_DST,
    output logic       REG_WRITE,
    output logic       EX_TOP,
    output logic       ALU_SRC,
    output logic [3:0] ALU_OP,
    output logic       MEM2REG,
    output logic       INSTR_DONE,
    output logic       ILLEGAL,
    output logic       MEM_TIMEOUT
);

    localparam int unsigned CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_ALU, WB_MEM, BRANCH, TRAP
    } state_e;

    typedef enum logic [3:0] {
        K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_LHI, K_LLO,
        K_LW, K_SW, K_BEQ, K_ILL
    } kind_e;

    function automatic kind_e decode(input logic [5:0] op, input logic [5:0] fn);
        kind_e k;
        k = K_ILL;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: k = K_ADD;
                    6'b100010: k = K_SUB;
                    6'b100100: k = K_AND;
                    6'b100101: k = K_OR;
                    6'b101010: k = K_SLT;
                    default:   k = K_ILL;
                endcase
            end
            6'b001000: k = K_ADDI;
            6'b011001: k = K_LHI;
            6'b011000: k = K_LLO;
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            6'b000100: k = K_BEQ;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    logic       mem_req_c, addr_src_c, mem_write_c, ir_write_c, pc_write_c, pc_src_c;
    logic       reg_dst_c, reg_write_c, ex_top_c, alu_src_c, mem2reg_c, done_c, illegal_c;
    logic [3:0] alu_op_c;
    logic       waiting;
    kind_e      dec_kind;

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        mem_req_c   = 1'b0;
        addr_src_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = 1'b0;
        reg_dst_c   = 1'b0;
        reg_write_c = 1'b0;
        ex_top_c    = 1'b0;
        alu_src_c   = 1'b0;
        alu_op_c    = 4'b0000;
        mem2reg_c   = 1'b0;
        done_c      = 1'b0;
        illegal_c   = 1'b0;
        dec_kind    = decode(OPCODE, FUNCT);

        case (state_q)
            FETCH: begin
                mem_req_c = 1'b1;
                if (MEM_READY) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                kind_d = dec_kind;
                case (dec_kind)
                    K_ADD, K_SUB, K_AND, K_OR, K_SLT: state_d = EXEC_R;
                    K_ADDI, K_LHI, K_LLO:             state_d = EXEC_I;
                    K_LW, K_SW:                       state_d = MEM_ADDR;
                    K_BEQ:                            state_d = BRANCH;
                    default: begin
                        illegal_c = 1'b1;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                        state_d = TRAP;
`else
                        done_c  = 1'b1;
                        state_d = FETCH;
`endif
                    end
                endcase
            end
            EXEC_R: begin
                case (kind_q)
                    K_SUB:   alu_op_c = 4'b0110;
                    K_AND:   alu_op_c = 4'b0000;
                    K_OR:    alu_op_c = 4'b0001;
                    K_SLT:   alu_op_c = 4'b0111;
                    default: alu_op_c = 4'b0010;
                endcase
                state_d = WB_ALU;
            end
            EXEC_I: begin
                alu_src_c = 1'b1;
                case (kind_q)
                    K_LHI:   alu_op_c = 4'b1000;
                    K_LLO:   alu_op_c = 4'b1001;
                    default: begin
                        ex_top_c = 1'b1;
                        alu_op_c = 4'b0010;
                    end
                endcase
                state_d = WB_ALU;
            end
            MEM_ADDR: begin
                alu_src_c = 1'b1;
                ex_top_c  = 1'b1;
                alu_op_c  = 4'b0010;
                state_d   = (kind_q == K_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req_c  = 1'b1;
                addr_src_c = 1'b1;
                if (MEM_READY) state_d = WB_MEM;
            end
            MEM_WR: begin
                mem_req_c   = 1'b1;
                addr_src_c  = 1'b1;
                mem_write_c = 1'b1;
                if (MEM_READY) begin
                    done_c  = 1'b1;
                    state_d = FETCH;
                end
            end
            WB_ALU: begin
                reg_write_c = 1'b1;
                mem2reg_c   = 1'b1;
                reg_dst_c   = kind_q inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT};
                done_c      = 1'b1;
                state_d     = FETCH;
            end
            WB_MEM: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_op_c   = 4'b0110;
                pc_write_c = ZERO;
                pc_src_c   = 1'b1;
                done_c     = 1'b1;
                state_d    = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // Watchdog saturates at the limit; the flag stays set but the FSM keeps waiting.
    always_comb begin
        waiting = mem_req_c & ~MEM_READY;
        cnt_d   = cnt_q;
        if (mem_req_c && MEM_READY) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != WAIT_LIM)) begin
            cnt_d = cnt_q + CW'(1);
        end
        timeout_d = timeout_q | (waiting & (cnt_d == WAIT_LIM));
    end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q | illegal_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            kind_q    <= K_ILL;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        MEM_REQ     = rst_n & mem_req_c;
        ADDR_SRC    = rst_n & addr_src_c;
        MEM_WRITE   = rst_n & mem_write_c;
        IR_WRITE    = rst_n & ir_write_c;
        PC_WRITE    = rst_n & pc_write_c;
        PC_SRC      = rst_n & pc_src_c;
        REG_DST     = rst_n & reg_dst_c;
        REG_WRITE   = rst_n & reg_write_c;
        EX_TOP      = rst_n & ex_top_c;
        ALU_SRC     = rst_n & alu_src_c;
        ALU_OP      = rst_n ? alu_op_c : 4'b0000;
        MEM2REG     = rst_n & mem2reg_c;
        INSTR_DONE  = rst_n & done_c;
        MEM_TIMEOUT = rst_n & timeout_q;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        ILLEGAL     = rst_n & illegal_q;
`else
        ILLEGAL     = rst_n & illegal_c;
`endif
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl: one row per clock cycle with hand-computed
// expected outputs, plus directed sequences for waits, timeout, reset abort and illegal opcodes.
`timescale 1ns/1ps

module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] OPCODE, FUNCT;
    logic       ZERO, MEM_READY;
    logic       MEM_REQ, ADDR_SRC, MEM_WRITE, IR_WRITE, PC_WRITE, PC_SRC;
    logic       REG_DST, REG_WRITE, EX_TOP, ALU_SRC, MEM2REG, INSTR_DONE, ILLEGAL, MEM_TIMEOUT;
    logic [3:0] ALU_OP;

    mips_multicycle_ctrl #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO),
        .MEM_READY(MEM_READY), .MEM_REQ(MEM_REQ), .ADDR_SRC(ADDR_SRC),
        .MEM_WRITE(MEM_WRITE), .IR_WRITE(IR_WRITE), .PC_WRITE(PC_WRITE),
        .PC_SRC(PC_SRC), .REG_DST(REG_DST), .REG_WRITE(REG_WRITE), .EX_TOP(EX_TOP),
        .ALU_SRC(ALU_SRC), .ALU_OP(ALU_OP), .MEM2REG(MEM2REG),
        .INSTR_DONE(INSTR_DONE), .ILLEGAL(ILLEGAL), .MEM_TIMEOUT(MEM_TIMEOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       req, asel, mw, irw, pcw, pcs, rdst, rw, ext, asrc;
        logic [3:0] op;
        logic       m2r, done, ill, to;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        out_t       exp;
        string      name;
    } vec_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LHI = 6'b011001;
    localparam logic [5:0] OP_LLO = 6'b011000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BAD = 6'b111111;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    function automatic out_t mk(input logic req, asel, mw, irw, pcw, pcs, rdst, rw, ext, asrc,
                                input logic [3:0] op, input logic m2r, done, ill, to);
        out_t o;
        o = {req, asel, mw, irw, pcw, pcs, rdst, rw, ext, asrc, op, m2r, done, ill, to};
        return o;
    endfunction

    out_t O_IDLE, O_FETCH_W, O_FETCH, O_WB_R, O_WB_I, O_MADDR, O_MRD, O_WB_MEM, O_MWR_W, O_MWR_D;

    task automatic check(input out_t exp, input string nm);
        out_t act;
        act = {MEM_REQ, ADDR_SRC, MEM_WRITE, IR_WRITE, PC_WRITE, PC_SRC, REG_DST, REG_WRITE,
               EX_TOP, ALU_SRC, ALU_OP, MEM2REG, INSTR_DONE, ILLEGAL, MEM_TIMEOUT};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (req asel mw irw pcw pcs rdst rw ext asrc op m2r done ill to)",
                     nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input out_t e, input string nm);
        rst_n = r; OPCODE = op; FUNCT = fn; ZERO = z; MEM_READY = rdy;
        @(negedge clk);
        check(e, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input out_t e, input string nm);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic add_r(input logic [5:0] fn, input logic [3:0] aop, input string nm);
        add(1, OP_R, fn, 0, 1, O_FETCH, {nm, "_fetch"});
        add(1, OP_R, fn, 0, 1, O_IDLE, {nm, "_decode"});
        add(1, OP_R, fn, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,aop,0,0,0,0), {nm, "_exec"});
        add(1, OP_R, fn, 0, 1, O_WB_R, {nm, "_wb"});
    endtask

    task automatic add_i(input logic [5:0] op, input logic ext, input logic [3:0] aop, input string nm);
        add(1, op, 6'd0, 0, 1, O_FETCH, {nm, "_fetch"});
        add(1, op, 6'd0, 0, 1, O_IDLE, {nm, "_decode"});
        add(1, op, 6'd0, 0, 1, mk(0,0,0,0,0,0,0,0,ext,1,aop,0,0,0,0), {nm, "_exec"});
        add(1, op, 6'd0, 0, 1, O_WB_I, {nm, "_wb"});
    endtask

    task automatic add_beq(input logic z, input string nm);
        add(1, OP_BEQ, 6'd0, z, 1, O_FETCH, {nm, "_fetch"});
        add(1, OP_BEQ, 6'd0, z, 1, O_IDLE, {nm, "_decode"});
        add(1, OP_BEQ, 6'd0, z, 1, mk(0,0,0,0,z,1,0,0,0,0,4'b0110,0,1,0,0), {nm, "_branch"});
    endtask

    initial begin
        rst_n = 1'b0; OPCODE = '0; FUNCT = '0; ZERO = 1'b0; MEM_READY = 1'b0;

        O_IDLE    = mk(0,0,0,0,0,0,0,0,0,0,4'b0000,0,0,0,0);
        O_FETCH_W = mk(1,0,0,0,0,0,0,0,0,0,4'b0000,0,0,0,0);
        O_FETCH   = mk(1,0,0,1,1,0,0,0,0,0,4'b0000,0,0,0,0);
        O_WB_R    = mk(0,0,0,0,0,0,1,1,0,0,4'b0000,1,1,0,0);
        O_WB_I    = mk(0,0,0,0,0,0,0,1,0,0,4'b0000,1,1,0,0);
        O_MADDR   = mk(0,0,0,0,0,0,0,0,1,1,4'b0010,0,0,0,0);
        O_MRD     = mk(1,1,0,0,0,0,0,0,0,0,4'b0000,0,0,0,0);
        O_WB_MEM  = mk(0,0,0,0,0,0,0,1,0,0,4'b0000,0,1,0,0);
        O_MWR_W   = mk(1,1,1,0,0,0,0,0,0,0,4'b0000,0,0,0,0);
        O_MWR_D   = mk(1,1,1,0,0,0,0,0,0,0,4'b0000,0,1,0,0);

        @(posedge clk);
        #1;

        add(0, OP_R, 6'd0, 0, 1, O_IDLE, "reset_outputs");
        add(1, OP_R, 6'b100000, 0, 0, O_FETCH_W, "first_fetch_wait");
        add_r(6'b100000, 4'b0010, "add");
        add_r(6'b100010, 4'b0110, "sub");
        add_r(6'b100100, 4'b0000, "and");
        add_r(6'b100101, 4'b0001, "or");
        add_r(6'b101010, 4'b0111, "slt");
        add_i(OP_ADDI, 1, 4'b0010, "addi");
        add_i(OP_LHI, 0, 4'b1000, "lhi");
        add_i(OP_LLO, 0, 4'b1001, "llo");
        add_beq(1, "beq_taken");
        add_beq(0, "beq_not_taken");
        add(1, OP_SW, 6'd0, 0, 1, O_FETCH, "sw_fetch");
        add(1, OP_SW, 6'd0, 0, 1, O_IDLE, "sw_decode");
        add(1, OP_SW, 6'd0, 0, 1, O_MADDR, "sw_addr");
        add(1, OP_SW, 6'd0, 0, 1, O_MWR_D, "sw_write");

        foreach (vecs[i])
            cyc(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy, vecs[i].exp, vecs[i].name);

        // LW with three memory wait cycles: eight cycles total
        cyc(1, OP_LW, 6'd0, 0, 1, O_FETCH, "lw_fetch");
        cyc(1, OP_LW, 6'd0, 0, 1, O_IDLE, "lw_decode");
        cyc(1, OP_LW, 6'd0, 0, 1, O_MADDR, "lw_addr");
        for (int k = 0; k < 3; k++) cyc(1, OP_LW, 6'd0, 0, 0, O_MRD, "lw_rd_wait");
        cyc(1, OP_LW, 6'd0, 0, 1, O_MRD, "lw_rd_ready");
        cyc(1, OP_LW, 6'd0, 0, 1, O_WB_MEM, "lw_wb");

        // SW held off for WAIT_MAX cycles: flag rises after the 15th wait cycle and sticks
        cyc(1, OP_SW, 6'd0, 0, 1, O_FETCH, "swto_fetch");
        cyc(1, OP_SW, 6'd0, 0, 1, O_IDLE, "swto_decode");
        cyc(1, OP_SW, 6'd0, 0, 1, O_MADDR, "swto_addr");
        for (int k = 0; k < 15; k++) cyc(1, OP_SW, 6'd0, 0, 0, O_MWR_W, "swto_wait_no_timeout");
        cyc(1, OP_SW, 6'd0, 0, 1, mk(1,1,1,0,0,0,0,0,0,0,4'b0000,0,1,0,1), "swto_done_timeout");
        cyc(1, OP_SW, 6'd0, 0, 1, mk(1,0,0,1,1,0,0,0,0,0,4'b0000,0,0,0,1), "sticky_fetch");
        cyc(1, OP_SW, 6'd0, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,4'b0000,0,0,0,1), "sticky_decode");
        cyc(1, OP_SW, 6'd0, 0, 1, mk(0,0,0,0,0,0,0,0,1,1,4'b0010,0,0,0,1), "sticky_addr");
        cyc(1, OP_SW, 6'd0, 0, 0, mk(1,1,1,0,0,0,0,0,0,0,4'b0000,0,0,0,1), "sticky_wr_wait");

        // Reset in the middle of the store wait aborts it with no strobe
        cyc(0, OP_SW, 6'd0, 0, 0, O_IDLE, "reset_mid_write");
        cyc(1, OP_SW, 6'd0, 0, 0, O_FETCH_W, "post_reset_fetch");
        cyc(1, OP_R, 6'b100110, 0, 1, O_FETCH, "badfn_fetch");

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        cyc(1, OP_R, 6'b100110, 0, 1, O_IDLE, "badfn_decode_trap");
        for (int k = 0; k < 4; k++)
            cyc(1, OP_R, 6'b100110, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,4'b0000,0,0,1,0), "trap_hold");
        cyc(0, OP_BAD, 6'd0, 0, 1, O_IDLE, "trap_reset");
        cyc(1, OP_BAD, 6'd0, 0, 1, O_FETCH, "bad_fetch");
        cyc(1, OP_BAD, 6'd0, 0, 1, O_IDLE, "bad_decode_trap");
        for (int k = 0; k < 3; k++)
            cyc(1, OP_BAD, 6'd0, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,4'b0000,0,0,1,0), "bad_trap_hold");
`else
        cyc(1, OP_R, 6'b100110, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,4'b0000,0,1,1,0), "badfn_decode_nop");
        cyc(1, OP_BAD, 6'd0, 0, 1, O_FETCH, "bad_fetch");
        cyc(1, OP_BAD, 6'd0, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,4'b0000,0,1,1,0), "bad_decode_nop");
        cyc(1, OP_BAD, 6'd0, 0, 0, O_FETCH_W, "bad_next_fetch");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
